// File: rtl/trig_lv1b_merge_pkg.sv
//==============================================================================
// Module : trig_cdt_pkg
// Brief  : Shared types and constants for the LV1B merge and tag serialiser.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package trig_cdt_pkg;

  localparam int N_TYPE_DEF = 8;
  localparam int EVT_W_DEF  = 16;

  localparam logic [31:0] CNT_SAT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  // Start bit, event number, then the type word.
  function automatic int FRAME_LEN(input int evt_w, input int n_type);
    return 1 + evt_w + n_type;
  endfunction

endpackage

`default_nettype wire

// File: rtl/trig_lv1b_merge_if.sv
//==============================================================================
// Module : trig_lv1b_merge_if
// Brief  : Trigger-type pulses in, accept and serial tag frame out.
// Rev    : 1.0
//==============================================================================
`default_nettype none

interface trig_lv1b_merge_if
  import trig_cdt_pkg::*;
#(
  parameter int N_TYPE = N_TYPE_DEF
);

  logic [N_TYPE-1:0] in_scaled;
  logic [N_TYPE-1:0] in_raw;
  logic              in_busy;
  logic              out_lv1b;
  logic [N_TYPE-1:0] out_trig_type;
  logic              out_ser_data;
  logic              out_ser_frame;

  modport master (
    output in_scaled,
    output in_raw,
    output in_busy,
    input  out_lv1b,
    input  out_trig_type,
    input  out_ser_data,
    input  out_ser_frame
  );

  modport slave (
    input  in_scaled,
    input  in_raw,
    input  in_busy,
    output out_lv1b,
    output out_trig_type,
    output out_ser_data,
    output out_ser_frame
  );

endinterface

`default_nettype wire

// File: rtl/trig_lv1b_merge_ser_tx.sv
//==============================================================================
// Module : trig_ser_tx
// Brief  : Parallel-load MSB-first shifter; frame high for the full word.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module trig_ser_tx
  import trig_cdt_pkg::*;
#(
  parameter int FRAME_W = FRAME_LEN(EVT_W_DEF, N_TYPE_DEF)
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               i_load,
  input  wire logic [FRAME_W-1:0] i_frame_word,
  output logic                    o_ser_data,
  output logic                    o_ser_frame,
  output logic                    o_done
);

  localparam int                c_cnt_w = $clog2(FRAME_W);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(FRAME_W - 1);

  logic [FRAME_W-1:0] r_shift;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_frame;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_frame <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_frame_word;
      r_cnt   <= c_last;
      r_frame <= 1'b1;
    end else if (r_frame) begin
      if (r_cnt == '0) begin
        r_frame <= 1'b0;
        r_shift <= '0;
      end else begin
        r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
        r_cnt   <= r_cnt - 1'b1;
      end
    end
  end

  assign o_ser_data  = r_frame & r_shift[FRAME_W-1];
  assign o_ser_frame = r_frame;
  assign o_done      = r_frame & (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/trig_lv1b_merge.sv
//==============================================================================
// Module : trig_lv1b_merge
// Brief  : Merges per-type LV1B pulses into one accept with serial tag frame,
//          hold-off and live-period counters. Optional raw monitor counter
//          enabled by macro TRIG_LV1B_RAW_MON_EN.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module trig_lv1b_merge
  import trig_cdt_pkg::*;
#(
  parameter int N_TYPE = N_TYPE_DEF,
  parameter int EVT_W  = EVT_W_DEF
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              in_live,
  input  wire logic [N_TYPE-1:0] user_type_mask,
  input  wire logic [15:0]       user_holdoff,
  trig_lv1b_merge_if.slave       bus,
  output logic [31:0]            lv1b_cnt,
`ifdef TRIG_LV1B_RAW_MON_EN
  output logic [31:0]            raw_cnt,
`endif
  output logic [31:0]            lost_cnt
);

  localparam int c_frame_w = FRAME_LEN(EVT_W, N_TYPE);

  state_t              r_state;
  logic                r_live_q;
  logic                r_lv1b;
  logic [N_TYPE-1:0]   r_trig_type;
  logic [15:0]         r_hold;
  logic [31:0]         r_lv1b_cnt;
  logic [31:0]         r_lost_cnt;

  logic                w_live_edge;
  logic [N_TYPE-1:0]   w_type;
  logic                w_req;
  logic                w_accept;
  logic                w_lost_inc;
  logic [31:0]         w_lv1b_base;
  logic [31:0]         w_lost_base;
  logic [c_frame_w-1:0] w_frame_word;
  logic                w_tx_done;

  // Counter clear on the live edge takes effect before any same-cycle increment.
  assign w_live_edge  = in_live & ~r_live_q;
  assign w_type       = bus.in_scaled & user_type_mask;
  assign w_req        = in_live & (|w_type);
  assign w_accept     = (r_state == IDLE) & w_req & ~bus.in_busy;
  assign w_lost_inc   = w_req & ~w_accept;
  assign w_lv1b_base  = w_live_edge ? 32'd0 : r_lv1b_cnt;
  assign w_lost_base  = w_live_edge ? 32'd0 : r_lost_cnt;
  assign w_frame_word = {1'b1, w_lv1b_base[EVT_W-1:0], w_type};

  trig_ser_tx #(
    .FRAME_W (c_frame_w)
  ) u_ser_tx (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_accept),
    .i_frame_word (w_frame_word),
    .o_ser_data   (bus.out_ser_data),
    .o_ser_frame  (bus.out_ser_frame),
    .o_done       (w_tx_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_live_q    <= 1'b0;
      r_lv1b      <= 1'b0;
      r_trig_type <= '0;
      r_hold      <= '0;
      r_lv1b_cnt  <= '0;
      r_lost_cnt  <= '0;
    end else begin
      r_live_q   <= in_live;
      r_lv1b     <= 1'b0;
      r_lv1b_cnt <= w_lv1b_base + {31'd0, w_accept};
      r_lost_cnt <= (w_lost_inc && (w_lost_base != CNT_SAT)) ? w_lost_base + 32'd1
                                                            : w_lost_base;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_lv1b      <= 1'b1;
            r_trig_type <= w_type;
            r_state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_tx_done) begin
            // Hold-off length is captured here; later changes wait for the next frame.
            if (user_holdoff != 16'd0) begin
              r_hold  <= user_holdoff - 16'd1;
              r_state <= HOLDOFF;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        HOLDOFF: begin
          if (r_hold == 16'd0) begin
            r_state <= IDLE;
          end else begin
            r_hold <= r_hold - 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.out_lv1b      = r_lv1b;
  assign bus.out_trig_type = r_trig_type;
  assign lv1b_cnt          = r_lv1b_cnt;
  assign lost_cnt          = r_lost_cnt;

`ifdef TRIG_LV1B_RAW_MON_EN
  logic [31:0] r_raw_cnt;
  logic [31:0] w_raw_base;
  logic        w_raw_hit;

  assign w_raw_base = w_live_edge ? 32'd0 : r_raw_cnt;
  assign w_raw_hit  = in_live & (|(bus.in_raw & user_type_mask));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raw_cnt <= '0;
    end else begin
      r_raw_cnt <= (w_raw_hit && (w_raw_base != CNT_SAT)) ? w_raw_base + 32'd1
                                                        : w_raw_base;
    end
  end

  assign raw_cnt = r_raw_cnt;
`else
  logic w_unused_raw;
  assign w_unused_raw = ^bus.in_raw;
`endif

endmodule

`default_nettype wire

// File: tb/tb_trig_lv1b_merge.sv
//==============================================================================
// Module : tb_trig_lv1b_merge
// Brief  : Directed bench for trig_lv1b_merge (honours TRIG_LV1B_RAW_MON_EN).
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_trig_lv1b_merge;
  import trig_cdt_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_live;
  logic [7:0]  user_type_mask;
  logic [15:0] user_holdoff;
  logic [31:0] lv1b_cnt;
  logic [31:0] lost_cnt;
`ifdef TRIG_LV1B_RAW_MON_EN
  logic [31:0] raw_cnt;
`endif

  int          n_tests;
  int          n_fail;
  logic [63:0] mon_word;
  int          mon_bits;
  int          mon_pulses;
  int          mon_stray;

  trig_lv1b_merge_if #(.N_TYPE(8)) bus ();

  trig_lv1b_merge #(
    .N_TYPE (8),
    .EVT_W  (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_live        (in_live),
    .user_type_mask (user_type_mask),
    .user_holdoff   (user_holdoff),
    .bus            (bus),
    .lv1b_cnt       (lv1b_cnt),
`ifdef TRIG_LV1B_RAW_MON_EN
    .raw_cnt        (raw_cnt),
`endif
    .lost_cnt       (lost_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame bits and accept pulses collected on the falling edge.
  always @(negedge clk) begin
    if (bus.out_ser_frame) begin
      mon_word = {mon_word[62:0], bus.out_ser_data};
      mon_bits++;
    end else if (bus.out_ser_data) begin
      mon_stray++;
    end
    if (bus.out_lv1b) mon_pulses++;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic mon_clear();
    mon_word   = '0;
    mon_bits   = 0;
    mon_pulses = 0;
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    mon_stray      = 0;
    mon_clear();
    rst_n          = 1'b0;
    in_live        = 1'b0;
    user_type_mask = 8'hFF;
    user_holdoff   = 16'd4;
    bus.in_scaled  = '0;
    bus.in_raw     = '0;
    bus.in_busy    = 1'b0;

    step(2);
    check("rst_lv1b",  64'(bus.out_lv1b), 64'd0);
    check("rst_type",  64'(bus.out_trig_type), 64'd0);
    check("rst_frame", 64'(bus.out_ser_frame), 64'd0);
    check("rst_cnt",   64'(lv1b_cnt), 64'd0);
    check("rst_lost",  64'(lost_cnt), 64'd0);

    rst_n = 1'b1;
    step(1);
    in_live = 1'b1;
    step(1);
    // T0: first request
    bus.in_scaled = 8'h05;
    mon_clear();
    step(1);
    bus.in_scaled = 8'h00;
    check("acc1_lv1b",  64'(bus.out_lv1b), 64'd1);
    check("acc1_type",  64'(bus.out_trig_type), 64'h05);
    check("acc1_frame", 64'(bus.out_ser_frame), 64'd1);
    step(1);
    check("acc1_width", 64'(bus.out_lv1b), 64'd0);
    step(8);
    // T0+10: request during SHIFT
    bus.in_scaled = 8'h02;
    step(1);
    bus.in_scaled = 8'h00;
    check("shift_lost",   64'(lost_cnt), 64'd1);
    check("shift_no_acc", 64'(bus.out_lv1b), 64'd0);
    step(14);
    check("frame1_last", 64'(bus.out_ser_frame), 64'd1);
    step(1);
    check("frame1_len",  64'(mon_bits), 64'd25);
    check("frame1_word", 64'(mon_word[24:0]), 64'h1000005);
    check("frame1_end",  64'(bus.out_ser_frame), 64'd0);
    check("cnt_after1",  64'(lv1b_cnt), 64'd1);
    step(3);
    // T0+29: last hold-off cycle, still rejected
    bus.in_scaled = 8'h08;
    step(1);
    check("holdoff_lost",   64'(lost_cnt), 64'd2);
    check("holdoff_no_acc", 64'(bus.out_lv1b), 64'd0);
    mon_clear();
    step(1);
    bus.in_scaled = 8'h00;
    check("acc2_lv1b", 64'(bus.out_lv1b), 64'd1);
    check("acc2_type", 64'(bus.out_trig_type), 64'h08);
    step(4);
    bus.in_busy = 1'b1;
    step(5);
    bus.in_busy = 1'b0;
    step(16);
    check("frame2_len",    64'(mon_bits), 64'd25);
    check("frame2_word",   64'(mon_word[24:0]), 64'h1000108);
    check("cnt_after2",    64'(lv1b_cnt), 64'd2);
    check("frame2_pulses", 64'(mon_pulses), 64'd1);

    // Live off, then a live edge while busy
    step(6);
    in_live       = 1'b0;
    bus.in_scaled = 8'hFF;
    step(1);
    in_live       = 1'b1;
    bus.in_busy   = 1'b1;
    bus.in_scaled = 8'h02;
    step(3);
    bus.in_scaled = 8'h00;
    bus.in_busy   = 1'b0;
    check("busy_lost",    64'(lost_cnt), 64'd3);
    check("busy_cnt",     64'(lv1b_cnt), 64'd0);
    check("busy_frame",   64'(bus.out_ser_frame), 64'd0);
    check("live0_no_acc", 64'(mon_pulses), 64'd1);

    // Mask filtering and zero hold-off
    user_type_mask = 8'h0F;
    bus.in_scaled  = 8'hF0;
    step(1);
    check("mask_no_acc",  64'(bus.out_lv1b), 64'd0);
    check("mask_no_lost", 64'(lost_cnt), 64'd3);
    bus.in_scaled = 8'hFF;
    user_holdoff  = 16'd0;
    mon_clear();
    step(1);
    bus.in_scaled = 8'h00;
    check("mask_lv1b", 64'(bus.out_lv1b), 64'd1);
    check("mask_type", 64'(bus.out_trig_type), 64'h0F);
    step(24);
    bus.in_scaled = 8'h01;
    step(1);
    check("frame3_len",  64'(mon_bits), 64'd25);
    check("frame3_word", 64'(mon_word[24:0]), 64'h100000F);
    check("lastbit_lost", 64'(lost_cnt), 64'd4);
    check("lastbit_no_acc", 64'(bus.out_lv1b), 64'd0);
    mon_clear();
    step(1);
    bus.in_scaled = 8'h00;
    check("h0_lv1b", 64'(bus.out_lv1b), 64'd1);
    check("h0_type", 64'(bus.out_trig_type), 64'h01);
    check("h0_cnt",  64'(lv1b_cnt), 64'd2);
    step(11);
    check("pre_rst_frame", 64'(bus.out_ser_frame), 64'd1);

    // Reset mid-frame
    rst_n = 1'b0;
    #1;
    check("midrst_frame", 64'(bus.out_ser_frame), 64'd0);
    check("midrst_data",  64'(bus.out_ser_data), 64'd0);
    check("midrst_type",  64'(bus.out_trig_type), 64'd0);
    check("midrst_cnt",   64'(lv1b_cnt), 64'd0);
    check("midrst_lost",  64'(lost_cnt), 64'd0);
    step(1);
    rst_n          = 1'b1;
    user_type_mask = 8'hFF;
    user_holdoff   = 16'd8;
    step(1);
    bus.in_scaled = 8'h03;
    mon_clear();
    step(1);
    bus.in_scaled = 8'h00;
    check("post_rst_lv1b", 64'(bus.out_lv1b), 64'd1);
    check("post_rst_type", 64'(bus.out_trig_type), 64'h03);
    step(25);
    check("frame4_len",  64'(mon_bits), 64'd25);
    check("frame4_word", 64'(mon_word[24:0]), 64'h1000003);
    check("frame4_cnt",  64'(lv1b_cnt), 64'd1);

    // Raw pulses during hold-off
    bus.in_raw = 8'h01;
    step(5);
    bus.in_raw = 8'h00;
    check("raw_cnt_hold", 64'(lv1b_cnt), 64'd1);
    check("raw_lost",     64'(lost_cnt), 64'd0);
`ifdef TRIG_LV1B_RAW_MON_EN
    check("raw_cnt", 64'(raw_cnt), 64'd5);
`endif
    step(2);
    check("stray_data", 64'(mon_stray), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
